mpt_plb_cache: RTL and testbench
================================

MPT_PLB_CACHE -- requirements
Module: mpt_plb_cache

Interface
REQ-001 Parameter NUM_ENTRIES, default 4: number of fully-associative PLB entries; legal values are powers of two from 2 to 32.
REQ-002 Parameter PA_WIDTH, default 34: supervisor physical address width; page number (PN) is PA_WIDTH-12 bits, taken from spa[PA_WIDTH-1:12].
REQ-003 Parameter SDID_WIDTH, default 6: supervisor domain ID width.
REQ-004 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 flush_i  in  1  invalidate all entries.
REQ-007 req_valid_i  in  1  lookup request valid.
REQ-008 req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high.
REQ-009 req_spa_i  in  PA_WIDTH  address to check.
REQ-010 req_sdid_i  in  SDID_WIDTH  requesting domain.
REQ-011 req_access_i  in  2  access type: 00 read, 01 write, 10 execute, 11 reserved.
REQ-012 rsp_valid_o  out  1  one-cycle response strobe.
REQ-013 rsp_allow_o  out  1  access allowed; valid only with rsp_valid_o.
REQ-014 rsp_fault_o  out  1  walker reported a fault; valid only with rsp_valid_o.
REQ-015 rsp_hit_o  out  1  response served from the PLB without a walk.
REQ-016 ptw_enable_o  out  1  one-cycle walk start pulse.
REQ-017 ptw_spa_o  out  PA_WIDTH  walk address; held stable from the pulse until walk completion.
REQ-018 ptw_valid_i  in  1  walk done; ptw_perm_i is valid.
REQ-019 ptw_fault_i  in  1  walk done with an access or format fault.
REQ-020 ptw_perm_i  in  3  permissions {x,w,r}.
REQ-021 hit_cnt_o, miss_cnt_o  out  32 each  saturating performance counters.

Function
REQ-022 Each entry SHALL hold: valid, PN, SDID, perm[2:0].
REQ-023 FSM states SHALL be IDLE, WALK_REQ, WALK_WAIT, RESP; req_ready_o = (state==IDLE) && !flush_i.
REQ-024 On acceptance, a hit (valid, PN match, SDID match) SHALL produce rsp_valid_o=1, rsp_hit_o=1, rsp_fault_o=0 on the next cycle, with state staying IDLE; the hit path has 1-cycle latency and back-to-back throughput.
REQ-025 On acceptance with a miss, the block SHALL latch spa, sdid and access, then go IDLE->WALK_REQ.
REQ-026 In WALK_REQ, ptw_enable_o=1 for exactly one cycle, followed by WALK_WAIT.
REQ-027 In WALK_WAIT, ptw_valid_i or ptw_fault_i SHALL move the FSM to RESP. If both are high, the fault wins.
REQ-028 On ptw_valid_i, the entry SHALL be filled at the lowest-index invalid entry; if none is invalid, it SHALL be filled at the round-robin victim pointer.
REQ-029 The round-robin victim pointer SHALL advance (wrap NUM_ENTRIES-1 -> 0) only when it is used for a fill.
REQ-030 RESP SHALL assert rsp_valid_o for one cycle with rsp_hit_o=0, then return to IDLE.
REQ-031 On a fault, RESP SHALL drive rsp_fault_o=1 and rsp_allow_o=0, and no fill SHALL occur.
REQ-032 rsp_allow_o SHALL equal perm[0] for read, perm[1] for write, perm[2] for execute, and 0 for reserved access; for a miss, perm is the walked permission.
REQ-033 flush_i SHALL clear every valid bit and the victim pointer on the next edge; the counters and FSM are unaffected.
REQ-034 If flush_i is asserted in WALK_REQ or WALK_WAIT, a sticky drop flag SHALL be set; that walk's result SHALL still be responded but not filled; the flag clears on RESP.
REQ-035 A fill coinciding with flush_i SHALL NOT occur.
REQ-036 hit_cnt_o SHALL increment per hit response and miss_cnt_o per walk start; both saturate at 0xFFFFFFFF.
REQ-037 ptw_valid_i and ptw_fault_i SHALL be ignored outside WALK_WAIT.

Reset
REQ-038 While rst_i is high: state=IDLE, all valid bits=0, victim pointer=0, drop flag=0, counters=0, and all outputs=0 except req_ready_o=1 (when flush_i=0).
REQ-039 Reset mid-walk SHALL abandon the walk with no response; ptw_spa_o resets to 0.

Verification
REQ-040 Cold miss: read of spa 0x0001_2345, sdid 3 -> one ptw_enable_o pulse with ptw_spa_o=0x0001_2345; the bench returns ptw_valid_i with perm=3'b001 -> rsp_allow_o=1, rsp_hit_o=0; a repeat read -> hit 1 cycle later; hit_cnt_o=1, miss_cnt_o=1.
REQ-041 Permission/SDID: after REQ-040, a write to the same page -> hit, rsp_allow_o=0; a read of the same page with sdid 4 -> miss and walk.
REQ-042 Replacement: with NUM_ENTRIES=4, fill pages 0-3, then miss on page 4 -> entry 0 replaced; page 0 then misses while pages 1-3 hit.
REQ-043 Fault: walk returns ptw_fault_i and ptw_valid_i together -> rsp_fault_o=1, rsp_allow_o=0; the next access to the same address walks again.
REQ-044 Flush races: flush_i during WALK_WAIT -> the response is delivered but a re-access misses; flush_i in IDLE with req_valid_i high -> req_ready_o=0 that cycle.
REQ-045 Counter saturation: preload via force to 0xFFFFFFFE and perform 3 hits -> hit_cnt_o holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/mpt_plb_cache_if.sv
// Lookup request/response bundle between a requester and the PLB cache.
interface mpt_plb_cache_if #(
   parameter int unsigned PA_WIDTH   = 34,
   parameter int unsigned SDID_WIDTH = 6
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic [PA_WIDTH-1:0]   req_spa;
   logic [SDID_WIDTH-1:0] req_sdid;
   logic [1:0]            req_access;
   logic                  rsp_valid;
   logic                  rsp_allow;
   logic                  rsp_fault;
   logic                  rsp_hit;

   modport master (
      output req_valid, req_spa, req_sdid, req_access,
      input  req_ready, rsp_valid, rsp_allow, rsp_fault, rsp_hit
   );

   modport slave (
      input  req_valid, req_spa, req_sdid, req_access,
      output req_ready, rsp_valid, rsp_allow, rsp_fault, rsp_hit
   );
endinterface

// File: rtl/mpt_plb_cache.sv
// Fully-associative permission lookaside buffer with a page-table walker
// handshake, round-robin replacement and saturating hit/miss counters.
module mpt_plb_cache #(
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned PA_WIDTH    = 34,
   parameter int unsigned SDID_WIDTH  = 6
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   mpt_plb_cache_if.slave      bus,
   output logic                ptw_enable_o,
   output logic [PA_WIDTH-1:0] ptw_spa_o,
   input  logic                ptw_valid_i,
   input  logic                ptw_fault_i,
   input  logic [2:0]          ptw_perm_i,
   output logic [31:0]         hit_cnt_o,
   output logic [31:0]         miss_cnt_o
);
   localparam int unsigned PnW  = PA_WIDTH - 12;
   localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {StIdle, StWalkReq, StWalkWait, StResp} state_e;

   state_e                                 state_q, state_d;
   logic [NUM_ENTRIES-1:0]                 ent_valid_q, ent_valid_d;
   logic [NUM_ENTRIES-1:0][PnW-1:0]        ent_pn_q, ent_pn_d;
   logic [NUM_ENTRIES-1:0][SDID_WIDTH-1:0] ent_sdid_q, ent_sdid_d;
   logic [NUM_ENTRIES-1:0][2:0]            ent_perm_q, ent_perm_d;
   logic [IdxW-1:0]                        victim_q, victim_d;
   logic                                   drop_q, drop_d;
   logic [PA_WIDTH-1:0]                    lat_spa_q, lat_spa_d;
   logic [SDID_WIDTH-1:0]                  lat_sdid_q, lat_sdid_d;
   logic [1:0]                             lat_acc_q, lat_acc_d;
   logic [2:0]                             rsp_perm_q, rsp_perm_d;
   logic                                   rsp_fault_q, rsp_fault_d;
   logic                                   hit_rsp_q, hit_rsp_d;
   logic                                   hit_allow_q, hit_allow_d;
   logic [31:0]                            hit_cnt_q, hit_cnt_d;
   logic [31:0]                            miss_cnt_q, miss_cnt_d;

   logic            hit;
   logic [2:0]      hit_perm;
   logic            free_found;
   logic [IdxW-1:0] free_idx;
   logic [IdxW-1:0] fill_idx;
   logic            fill;
   logic            accept;

   function automatic logic allow_sel(input logic [2:0] perm, input logic [1:0] acc);
      unique case (acc)
         2'b00:   return perm[0];
         2'b01:   return perm[1];
         2'b10:   return perm[2];
         default: return 1'b0;
      endcase
   endfunction

   assign bus.req_ready = (state_q == StIdle) && !flush_i;
   assign accept        = bus.req_valid && bus.req_ready;

   // Associative match of the incoming request against all valid entries.
   always_comb begin
      hit      = 1'b0;
      hit_perm = '0;
      for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
         if (ent_valid_q[i] && ent_pn_q[i] == bus.req_spa[PA_WIDTH-1:12] &&
             ent_sdid_q[i] == bus.req_sdid) begin
            hit      = 1'b1;
            hit_perm = ent_perm_q[i];
         end
      end
   end

   // Lowest-index invalid entry is preferred over the victim pointer.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
         if (!ent_valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IdxW'(i);
         end
      end
   end

   // Next-state: FSM, fill, flush and counters.
   always_comb begin
      state_d     = state_q;
      ent_valid_d = ent_valid_q;
      ent_pn_d    = ent_pn_q;
      ent_sdid_d  = ent_sdid_q;
      ent_perm_d  = ent_perm_q;
      victim_d    = victim_q;
      drop_d      = drop_q;
      lat_spa_d   = lat_spa_q;
      lat_sdid_d  = lat_sdid_q;
      lat_acc_d   = lat_acc_q;
      rsp_perm_d  = rsp_perm_q;
      rsp_fault_d = rsp_fault_q;
      hit_rsp_d   = 1'b0;
      hit_allow_d = 1'b0;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      fill        = 1'b0;
      fill_idx    = free_found ? free_idx : victim_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (hit) begin
                  hit_rsp_d   = 1'b1;
                  hit_allow_d = allow_sel(hit_perm, bus.req_access);
                  if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
               end else begin
                  lat_spa_d  = bus.req_spa;
                  lat_sdid_d = bus.req_sdid;
                  lat_acc_d  = bus.req_access;
                  state_d    = StWalkReq;
               end
            end
         end
         StWalkReq: begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            if (flush_i) drop_d = 1'b1;
            state_d = StWalkWait;
         end
         StWalkWait: begin
            if (flush_i) drop_d = 1'b1;
            if (ptw_fault_i) begin
               rsp_fault_d = 1'b1;
               state_d     = StResp;
            end else if (ptw_valid_i) begin
               rsp_fault_d = 1'b0;
               rsp_perm_d  = ptw_perm_i;
               // A walk overlapped by a flush may hold stale permissions.
               fill        = !drop_q && !flush_i;
               state_d     = StResp;
            end
         end
         StResp: begin
            drop_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (fill) begin
         ent_valid_d[fill_idx] = 1'b1;
         ent_pn_d[fill_idx]    = lat_spa_q[PA_WIDTH-1:12];
         ent_sdid_d[fill_idx]  = lat_sdid_q;
         ent_perm_d[fill_idx]  = rsp_perm_d;
         if (!free_found) victim_d = victim_q + IdxW'(1);
      end

      if (flush_i) begin
         ent_valid_d = '0;
         victim_d    = '0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         ent_valid_q <= '0;
         ent_pn_q    <= '0;
         ent_sdid_q  <= '0;
         ent_perm_q  <= '0;
         victim_q    <= '0;
         drop_q      <= 1'b0;
         lat_spa_q   <= '0;
         lat_sdid_q  <= '0;
         lat_acc_q   <= '0;
         rsp_perm_q  <= '0;
         rsp_fault_q <= 1'b0;
         hit_rsp_q   <= 1'b0;
         hit_allow_q <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ent_valid_q <= ent_valid_d;
         ent_pn_q    <= ent_pn_d;
         ent_sdid_q  <= ent_sdid_d;
         ent_perm_q  <= ent_perm_d;
         victim_q    <= victim_d;
         drop_q      <= drop_d;
         lat_spa_q   <= lat_spa_d;
         lat_sdid_q  <= lat_sdid_d;
         lat_acc_q   <= lat_acc_d;
         rsp_perm_q  <= rsp_perm_d;
         rsp_fault_q <= rsp_fault_d;
         hit_rsp_q   <= hit_rsp_d;
         hit_allow_q <= hit_allow_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign bus.rsp_valid = hit_rsp_q || (state_q == StResp);
   assign bus.rsp_hit   = hit_rsp_q;
   assign bus.rsp_fault = (state_q == StResp) && rsp_fault_q;
   assign bus.rsp_allow = hit_rsp_q ? hit_allow_q :
                          ((state_q == StResp) && !rsp_fault_q &&
                           allow_sel(rsp_perm_q, lat_acc_q));
   assign ptw_enable_o  = (state_q == StWalkReq);
   assign ptw_spa_o     = lat_spa_q;
   assign hit_cnt_o     = hit_cnt_q;
   assign miss_cnt_o    = miss_cnt_q;
endmodule

// File: tb/tb_mpt_plb_cache.sv
// Randomized bench for mpt_plb_cache against a transaction-level PLB model.
module tb_mpt_plb_cache;
   localparam int N   = 4;
   localparam int PAW = 34;
   localparam int SW  = 6;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           flush_i = 1'b0;
   logic           ptw_enable_o;
   logic [PAW-1:0] ptw_spa_o;
   logic           ptw_valid_i = 1'b0;
   logic           ptw_fault_i = 1'b0;
   logic [2:0]     ptw_perm_i = 3'b000;
   logic [31:0]    hit_cnt_o, miss_cnt_o;

   mpt_plb_cache_if #(.PA_WIDTH(PAW), .SDID_WIDTH(SW)) bus ();

   mpt_plb_cache #(.NUM_ENTRIES(N), .PA_WIDTH(PAW), .SDID_WIDTH(SW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush_i),
      .bus          (bus),
      .ptw_enable_o (ptw_enable_o),
      .ptw_spa_o    (ptw_spa_o),
      .ptw_valid_i  (ptw_valid_i),
      .ptw_fault_i  (ptw_fault_i),
      .ptw_perm_i   (ptw_perm_i),
      .hit_cnt_o    (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: the cache contents as a plain table.
   bit             m_valid[N];
   logic [PAW-13:0] m_pn[N];
   logic [SW-1:0]  m_sdid[N];
   logic [2:0]     m_perm[N];
   int             m_vptr = 0;
   logic [31:0]    m_hit = 0;
   logic [31:0]    m_miss = 0;

   typedef struct {int due; bit hit; bit allow; bit fault;} rsp_t;
   typedef struct {int due; logic [PAW-1:0] spa;} walk_t;
   rsp_t  rq[$];
   walk_t wq[$];
   rsp_t  cur_r;
   walk_t cur_w;

   bit             hold = 1'b0;
   logic [PAW-1:0] hold_spa = '0;
   bit             last_hit, last_allow, last_fault;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit m_allow(input logic [2:0] p, input logic [1:0] a);
      if (a == 2'd3) return 1'b0;
      return p[a];
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic model_flush();
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_vptr = 0;
   endtask

   task automatic model_fill(input logic [PAW-1:0] spa, input logic [SW-1:0] sd,
                             input logic [2:0] p);
      int idx = -1;
      for (int i = 0; i < N; i++) if (!m_valid[i] && idx < 0) idx = i;
      if (idx < 0) begin
         idx = m_vptr;
         m_vptr = (m_vptr + 1) % N;
      end
      m_valid[idx] = 1'b1;
      m_pn[idx]    = spa[PAW-1:12];
      m_sdid[idx]  = sd;
      m_perm[idx]  = p;
   endtask

   // Single compare process: responses, walk pulses and walk-address stability.
   always @(negedge clk) begin
      if (bus.rsp_valid) begin
         if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_unexpected: got rsp_valid=1, required 0 (cycle %0d)", cyc);
         end else begin
            cur_r = rq.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(cur_r.due));
            chk("rsp_hit", 64'(bus.rsp_hit), 64'(cur_r.hit));
            chk("rsp_allow", 64'(bus.rsp_allow), 64'(cur_r.allow));
            chk("rsp_fault", 64'(bus.rsp_fault), 64'(cur_r.fault));
         end
         last_hit   = bus.rsp_hit;
         last_allow = bus.rsp_allow;
         last_fault = bus.rsp_fault;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_missing: got rsp_valid=0, required 1 (cycle %0d)", cyc);
         void'(rq.pop_front());
      end
      if (ptw_enable_o) begin
         if (wq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL walk_unexpected: got ptw_enable=1, required 0 (cycle %0d)", cyc);
         end else begin
            cur_w = wq.pop_front();
            chk("walk_cycle", 64'(cyc), 64'(cur_w.due));
            chk("walk_spa", 64'(ptw_spa_o), 64'(cur_w.spa));
         end
      end else if (wq.size() > 0 && wq[0].due <= cyc) begin
         n_cmp++; n_bad++;
         $display("FAIL walk_missing: got ptw_enable=0, required 1 (cycle %0d)", cyc);
         void'(wq.pop_front());
      end
      if (hold) chk("walk_spa_hold", 64'(ptw_spa_o), 64'(hold_spa));
   end

   // One lookup; on a miss the bench plays the walker with optional flush/spurious events.
   // flush_at: 0 none, 1 during WALK_REQ, 2 with the walk result, 3 early in WALK_WAIT.
   task automatic do_req(input logic [PAW-1:0] spa, input logic [SW-1:0] sd, input logic [1:0] acc,
                         input int wait_c, input bit flt, input bit both, input logic [2:0] perm,
                         input int flush_at, input bit spur);
      int guard = 0;
      bit h = 1'b0;
      bit drop = 1'b0;
      logic [2:0] hp = '0;
      while (!bus.req_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 50) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got req_ready=0, required 1 (cycle %0d)", cyc);
            return;
         end
      end
      for (int i = 0; i < N; i++)
         if (m_valid[i] && m_pn[i] == spa[PAW-1:12] && m_sdid[i] == sd) begin
            h = 1'b1;
            hp = m_perm[i];
         end
      bus.req_valid  = 1'b1;
      bus.req_spa    = spa;
      bus.req_sdid   = sd;
      bus.req_access = acc;
      if (h) begin
         rq.push_back('{due: cyc + 1, hit: 1'b1, allow: m_allow(hp, acc), fault: 1'b0});
         m_hit = sat_inc(m_hit);
      end else begin
         wq.push_back('{due: cyc + 1, spa: spa});
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (!h) begin
         m_miss   = sat_inc(m_miss);
         hold     = 1'b1;
         hold_spa = spa;
         if (spur) begin
            ptw_valid_i = 1'b1;
            ptw_fault_i = 1'b1;
            ptw_perm_i  = 3'($urandom);
         end
         if (flush_at == 1) begin
            flush_i = 1'b1; model_flush(); drop = 1'b1;
         end
         for (int i = 0; i < wait_c; i++) begin
            @(negedge clk);
            ptw_valid_i = 1'b0;
            ptw_fault_i = 1'b0;
            flush_i     = 1'b0;
            if (flush_at == 3 && i == 0 && wait_c > 1) begin
               flush_i = 1'b1; model_flush(); drop = 1'b1;
            end
         end
         if (flush_at == 2) begin
            flush_i = 1'b1; model_flush(); drop = 1'b1;
         end
         ptw_fault_i = flt;
         ptw_valid_i = !flt || both;
         ptw_perm_i  = perm;
         rq.push_back('{due: cyc + 1, hit: 1'b0, allow: flt ? 1'b0 : m_allow(perm, acc),
                        fault: flt});
         if (!flt && !drop) model_fill(spa, sd, perm);
         @(negedge clk);
         ptw_valid_i = 1'b0;
         ptw_fault_i = 1'b0;
         flush_i     = 1'b0;
         hold        = 1'b0;
      end
      #1;
      chk("hit_cnt", 64'(hit_cnt_o), 64'(m_hit));
      chk("miss_cnt", 64'(miss_cnt_o), 64'(m_miss));
   endtask

   // Flush in IDLE while a request is presented: it must not be accepted.
   task automatic flush_idle_race(input logic [PAW-1:0] spa);
      int guard = 0;
      while (!bus.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      bus.req_valid  = 1'b1;
      bus.req_spa    = spa;
      bus.req_sdid   = '0;
      bus.req_access = 2'd0;
      flush_i        = 1'b1;
      #1;
      chk("ready_during_flush", 64'(bus.req_ready), 64'd0);
      model_flush();
      @(negedge clk);
      bus.req_valid = 1'b0;
      flush_i       = 1'b0;
      #1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got no finish, required finish by 500us");
      $fatal(1);
   end

   initial begin
      logic [PAW-1:0] spa;
      int r;
      bus.req_valid  = 1'b0;
      bus.req_spa    = '0;
      bus.req_sdid   = '0;
      bus.req_access = 2'd0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_allow", 64'(bus.rsp_allow), 64'd0);
      chk("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
      chk("rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);
      chk("rst_ptw_enable", 64'(ptw_enable_o), 64'd0);
      chk("rst_ptw_spa", 64'(ptw_spa_o), 64'd0);
      chk("rst_hit_cnt", 64'(hit_cnt_o), 64'd0);
      chk("rst_miss_cnt", 64'(miss_cnt_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Cold miss then hit.
      do_req(34'h0_0001_2345, 6'd3, 2'd0, 2, 1'b0, 1'b0, 3'b001, 0, 1'b0);
      chk("cold_hit", 64'(last_hit), 64'd0);
      chk("cold_allow", 64'(last_allow), 64'd1);
      do_req(34'h0_0001_2345, 6'd3, 2'd0, 1, 1'b0, 1'b0, 3'b001, 0, 1'b0);
      chk("warm_hit", 64'(last_hit), 64'd1);
      chk("warm_allow", 64'(last_allow), 64'd1);
      chk("cold_hit_cnt", 64'(hit_cnt_o), 64'd1);
      chk("cold_miss_cnt", 64'(miss_cnt_o), 64'd1);

      // Permission and SDID.
      do_req(34'h0_0001_2000, 6'd3, 2'd1, 1, 1'b0, 1'b0, 3'b001, 0, 1'b0);
      chk("write_hit", 64'(last_hit), 64'd1);
      chk("write_allow", 64'(last_allow), 64'd0);
      do_req(34'h0_0001_2345, 6'd4, 2'd0, 1, 1'b0, 1'b0, 3'b011, 0, 1'b1);
      chk("sdid_hit", 64'(last_hit), 64'd0);
      chk("sdid_miss_cnt", 64'(miss_cnt_o), 64'd2);

      flush_idle_race(34'h0_0001_2345);

      // Replacement: pages 0-3 fill, page 4 evicts entry 0.
      for (int p = 0; p < 5; p++)
         do_req(34'(p) << 12, 6'd1, 2'd0, 1, 1'b0, 1'b0, 3'b001, 0, 1'b0);
      for (int p = 1; p < 4; p++) begin
         do_req(34'(p) << 12, 6'd1, 2'd0, 1, 1'b0, 1'b0, 3'b001, 0, 1'b0);
         chk("repl_keep_hit", 64'(last_hit), 64'd1);
      end
      do_req(34'h0, 6'd1, 2'd0, 1, 1'b0, 1'b0, 3'b001, 0, 1'b0);
      chk("repl_evicted_hit", 64'(last_hit), 64'd0);

      // Fault with valid also high.
      do_req(34'h0_000A_0000, 6'd2, 2'd0, 2, 1'b1, 1'b1, 3'b111, 0, 1'b0);
      chk("fault_flag", 64'(last_fault), 64'd1);
      chk("fault_allow", 64'(last_allow), 64'd0);
      do_req(34'h0_000A_0000, 6'd2, 2'd0, 1, 1'b0, 1'b0, 3'b111, 0, 1'b0);
      chk("after_fault_hit", 64'(last_hit), 64'd0);

      // Flush during WALK_WAIT: response delivered, no fill.
      do_req(34'h0_000B_0000, 6'd2, 2'd0, 3, 1'b0, 1'b0, 3'b001, 3, 1'b0);
      chk("flush_walk_allow", 64'(last_allow), 64'd1);
      do_req(34'h0_000B_0000, 6'd2, 2'd0, 1, 1'b0, 1'b0, 3'b001, 0, 1'b0);
      chk("flush_walk_refetch", 64'(last_hit), 64'd0);

      // Randomized traffic over a page pool larger than the cache.
      for (int t = 0; t < 250; t++) begin
         spa = (34'($urandom_range(0, 5)) << 12) | 34'($urandom_range(0, 4095));
         r = $urandom_range(0, 15);
         if ($urandom_range(0, 19) == 0) flush_idle_race(spa);
         do_req(spa, 6'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom_range(1, 4), ($urandom_range(0, 7) == 0), 1'($urandom),
                3'($urandom), (r < 3) ? r + 1 : 0, ($urandom_range(0, 3) == 0));
      end

      // Hit counter saturation.
      do_req(34'h0_0009_0000, 6'd1, 2'd0, 1, 1'b0, 1'b0, 3'b111, 0, 1'b0);
      force dut.hit_cnt_q = 32'hFFFF_FFFE;
      @(posedge clk);
      @(negedge clk);
      release dut.hit_cnt_q;
      m_hit = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++)
         do_req(34'h0_0009_0000, 6'd1, 2'd0, 1, 1'b0, 1'b0, 3'b111, 0, 1'b0);
      chk("sat_last_hit", 64'(last_hit), 64'd1);
      chk("sat_hit_cnt", 64'(hit_cnt_o), 64'hFFFF_FFFF);

      // Reset in the middle of a walk.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_spa    = 34'h0_03FF_0000;
      bus.req_sdid   = 6'd9;
      bus.req_access = 2'd0;
      wq.push_back('{due: cyc + 1, spa: 34'h0_03FF_0000});
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midwalk_rst_spa", 64'(ptw_spa_o), 64'd0);
      chk("midwalk_rst_hit_cnt", 64'(hit_cnt_o), 64'd0);
      model_flush();
      m_hit  = 0;
      m_miss = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      do_req(34'h0_0009_0000, 6'd1, 2'd0, 1, 1'b0, 1'b0, 3'b111, 0, 1'b0);
      chk("post_rst_hit", 64'(last_hit), 64'd0);
      chk("post_rst_miss_cnt", 64'(miss_cnt_o), 64'd1);
      repeat (3) @(negedge clk);
      chk("drain_rsp", 64'(rq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
